// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC register and single-outstanding instruction fetch requester with redirect/discard handling.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned fetch raises adelF instead of issuing a request).
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] pcnextbrFD,
   input  logic        stallF,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pcF,
   output logic [31:0] pcplus4F,
   output logic [31:0] instrF,
   output logic        instr_validF,
   output logic        adelF,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata
);

   typedef enum logic [2:0] {
      BOOT,
      REQ,
      WAIT,
      HOLD,
      DISCARD
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] pend_pc_reg, pend_pc_next;
   logic        pend_v_reg, pend_v_next;
   logic        misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
   logic adel_reg, adel_next;
   assign misaligned = (pc_reg[1:0] != 2'b00);
   assign adelF      = adel_reg;
`else
   assign misaligned = 1'b0;
   assign adelF      = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= BOOT;
         pc_reg      <= RESET_PC;
         instr_reg   <= 32'h0;
         pend_pc_reg <= 32'h0;
         pend_v_reg  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         adel_reg    <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         instr_reg   <= instr_next;
         pend_pc_reg <= pend_pc_next;
         pend_v_reg  <= pend_v_next;
`ifdef FETCH_ALIGN_CHECK_EN
         adel_reg    <= adel_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      instr_next   = instr_reg;
      pend_pc_next = pend_pc_reg;
      pend_v_next  = pend_v_reg;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_next    = adel_reg;
`endif
      case (state_reg)
         BOOT: begin
            if (redirect_valid) pc_next = redirect_pc;
            state_next = REQ;
         end
         REQ: begin
            if (misaligned) begin
               // No request is on the bus, so a redirect can take effect immediately.
               if (redirect_valid) begin
                  pc_next = redirect_pc;
               end else begin
                  instr_next = 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
                  adel_next  = 1'b1;
`endif
                  state_next = HOLD;
               end
            end else begin
               // Request must stay stable until accepted; a redirect is parked in pend.
               if (redirect_valid) begin
                  pend_pc_next = redirect_pc;
                  pend_v_next  = 1'b1;
               end
               if (inst_addr_ok)
                  state_next = (pend_v_reg || redirect_valid) ? DISCARD : WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               if (inst_data_ok) begin
                  pc_next    = redirect_pc;
                  state_next = REQ;
               end else begin
                  pend_pc_next = redirect_pc;
                  pend_v_next  = 1'b1;
                  state_next   = DISCARD;
               end
            end else if (inst_data_ok) begin
               instr_next = inst_rdata;
               state_next = HOLD;
            end
         end
         DISCARD: begin
            if (redirect_valid) pend_pc_next = redirect_pc;
            if (inst_data_ok) begin
               pc_next     = redirect_valid ? redirect_pc : pend_pc_reg;
               pend_v_next = 1'b0;
               state_next  = REQ;
            end
         end
         HOLD: begin
            if (redirect_valid || !stallF) begin
               pc_next    = redirect_valid ? redirect_pc : pcnextbrFD;
               state_next = REQ;
`ifdef FETCH_ALIGN_CHECK_EN
               adel_next  = 1'b0;
`endif
            end
         end
         default: state_next = BOOT;
      endcase
   end

   assign pcF          = pc_reg;
   assign pcplus4F     = pc_reg + 32'd4;
   assign instrF       = instr_reg;
   assign instr_validF = (state_reg == HOLD);
   assign inst_req     = (state_reg == REQ) && !misaligned;
   assign inst_addr    = pc_reg;

endmodule
